// File: rtl/cheby_t_table_writer.sv
// Chebyshev T(k)(x) table writer: streams T(0)..T(N_TERMS-1) for a latched
// Q1.15 point x into an external table through a valid/ready write port.
module cheby_t_table_writer #(
    parameter int N_TERMS = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              c_clk,
    input  logic              c_rst_n,
    input  logic              c_start,
    input  logic [15:0]       i_x,
    input  logic              c_wr_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_CALC,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TERMS - 1);
    localparam logic [15:0]       T0_VAL = 16'h7FFF;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] k;
    logic signed [15:0] x_reg;
    logic signed [15:0] t1;
    logic signed [15:0] t2;
    logic               sat_q;

    logic signed [31:0] prod;
    logic signed [31:0] q;
    logic signed [31:0] s;
    logic               clip_hi;
    logic               clip_lo;
    logic [15:0]        t_next;

    logic start_go;
    logic w0_go;
    logic calc_go;
    logic done_go;

    // t1 holds the last written term T(k), t2 the one before it
    assign prod    = x_reg * t1;
    assign q       = prod >>> 14;
    assign s       = q - 32'(t2);
    assign clip_hi = s > 32'sd32767;
    assign clip_lo = s < -32'sd32768;

    always_comb begin
        t_next = s[15:0];
        if (clip_hi) begin
            t_next = 16'h7FFF;
        end else if (clip_lo) begin
            t_next = 16'h8000;
        end
    end

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        start_go  = 1'b0;
        w0_go     = 1'b0;
        calc_go   = 1'b0;
        done_go   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (c_start) begin
                    start_go = 1'b1;
                    state_nx = S_W0;
                end
            end
            S_W0: begin
                o_wr_en   = 1'b1;
                o_wr_data = T0_VAL;
                if (c_wr_ready) begin
                    w0_go    = 1'b1;
                    state_nx = S_W1;
                end
            end
            S_W1: begin
                o_wr_en   = 1'b1;
                o_wr_addr = k;
                o_wr_data = x_reg;
                if (c_wr_ready) begin
                    state_nx = (k == K_LAST) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                calc_go  = 1'b1;
                state_nx = S_WR;
            end
            S_WR: begin
                o_wr_en   = 1'b1;
                o_wr_addr = k;
                o_wr_data = t1;
                if (c_wr_ready) begin
                    state_nx = (k == K_LAST) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                done_go  = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            k     <= '0;
            x_reg <= '0;
            t1    <= '0;
            t2    <= '0;
            sat_q <= 1'b0;
        end else begin
            if (start_go) begin
                x_reg <= i_x;
                sat_q <= 1'b0;
                k     <= '0;
            end
            if (w0_go) begin
                k  <= ADDR_W'(1);
                t2 <= T0_VAL;
                t1 <= x_reg;
            end
            if (calc_go) begin
                t2 <= t1;
                t1 <= t_next;
                k  <= k + ADDR_W'(1);
                if (clip_hi || clip_lo) begin
                    sat_q <= 1'b1;
                end
            end
            if (done_go) begin
                k <= '0;
            end
        end
    end

    assign o_busy = (state != S_IDLE);
    assign o_done = (state == S_DONE);
    assign o_sat  = sat_q;

endmodule

// File: tb/tb_cheby_t_table_writer.sv
// Bench for cheby_t_table_writer: directed and random runs against an
// integer Chebyshev recurrence model with saturation.
module tb_cheby_t_table_writer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic        ready;
    logic        en;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        sat;

    cheby_t_table_writer #(.N_TERMS(N), .ADDR_W(3)) dut (
        .c_clk(clk),
        .c_rst_n(rst_n),
        .c_start(start),
        .i_x(x),
        .c_wr_ready(ready),
        .o_wr_en(en),
        .o_wr_addr(addr),
        .o_wr_data(data),
        .o_busy(busy),
        .o_done(done),
        .o_sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int e0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int dq[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (en === 1'b1 && ready === 1'b1) begin
                wq_addr.push_back(int'(addr));
                wq_data.push_back(int'(data));
                wq_cyc.push_back(cyc - e0 + 1);
            end
            if (done === 1'b1) dq.push_back(cyc - e0 + 1);
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    logic [15:0] exp_t[N];
    bit          exp_sat;

    task automatic model(input logic [15:0] xv);
        int a, t1v, t2v, p, s;
        a = $signed(xv);
        exp_t[0] = 16'h7FFF;
        exp_t[1] = xv;
        exp_sat = 1'b0;
        t2v = 32767;
        t1v = a;
        for (int kk = 2; kk < N; kk++) begin
            p = a * t1v;
            s = (p >>> 14) - t2v;
            if (s > 32767) begin
                s = 32767;
                exp_sat = 1'b1;
            end else if (s < -32768) begin
                s = -32768;
                exp_sat = 1'b1;
            end
            exp_t[kk] = s[15:0];
            t2v = t1v;
            t1v = s;
        end
    endtask

    function automatic int wcyc(input int kk, input int extra);
        if (kk == 0) return 1;
        if (kk == 1) return 2;
        return 2 * kk + extra;
    endfunction

    task automatic kick(input logic [15:0] xv);
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        dq.delete();
        @(posedge clk);
        #1;
        x = xv;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0;
        x = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        n = 0;
        while (dq.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        ok = (dq.size() != 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        x = 16'h0;
        #17;
        n_checks++;
        if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_ctrl got en=%b busy=%b done=%b want 0/0/0",
                     en, busy, done);
        else n_pass++;
        n_checks++;
        if (addr !== 3'd0 || data !== 16'h0 || sat !== 1'b0)
            $display("FAIL reset_data got a=%0d d=%h sat=%b want 0/0000/0",
                     addr, data, sat);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_zero();
        logic [15:0] lit[N];
        bit ok;
        lit = '{16'h7FFF, 16'h0000, 16'h8001, 16'h0000,
                16'h7FFF, 16'h0000, 16'h8001, 16'h0000};
        ready = 1'b1;
        kick(16'h0000);
        wait_done(60, ok);
        n_checks++;
        if (!ok || dq[0] !== 15)
            $display("FAIL zero_done got ok=%0d cyc=%0d want 1/15", ok,
                     ok ? dq[0] : -1);
        else n_pass++;
        n_checks++;
        if (wq_addr.size() !== N)
            $display("FAIL zero_count got %0d want %0d", wq_addr.size(), N);
        else n_pass++;
        for (int i = 0; i < N && i < wq_addr.size(); i++) begin
            n_checks++;
            if (wq_addr[i] !== i || wq_data[i] !== int'(lit[i]) ||
                wq_cyc[i] !== wcyc(i, 0))
                $display("FAIL zero_w%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                         i, wq_addr[i], wq_data[i], wq_cyc[i], i, lit[i], wcyc(i, 0));
            else n_pass++;
        end
        n_checks++;
        if (sat !== 1'b0) $display("FAIL zero_sat got %b want 0", sat);
        else n_pass++;
    endtask

    task automatic test_min();
        bit ok;
        model(16'h8000);
        ready = 1'b1;
        kick(16'h8000);
        wait_done(60, ok);
        n_checks++;
        if (!ok || wq_data.size() < 3 || wq_data[1] !== 'h8000 ||
            wq_data[2] !== 'h7FFF)
            $display("FAIL min_t12 got ok=%0d n=%0d want 8000/7FFF", ok,
                     wq_data.size());
        else n_pass++;
        for (int i = 0; i < N && i < wq_addr.size(); i++) begin
            n_checks++;
            if (wq_addr[i] !== i || wq_data[i] !== int'(exp_t[i]))
                $display("FAIL min_w%0d got a=%0d d=%h want a=%0d d=%h",
                         i, wq_addr[i], wq_data[i], i, exp_t[i]);
            else n_pass++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sat !== 1'b1 || busy !== 1'b0)
            $display("FAIL min_sticky got sat=%b busy=%b want 1/0", sat, busy);
        else n_pass++;
    endtask

    task automatic test_max();
        bit ok;
        model(16'h7FFF);
        ready = 1'b1;
        kick(16'h7FFF);
        @(negedge clk);
        n_checks++;
        if (sat !== 1'b0) $display("FAIL max_satclr got %b want 0", sat);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++;
        if (sat !== 1'b0) $display("FAIL max_sat_t3 got %b want 0", sat);
        else n_pass++;
        wait_done(60, ok);
        n_checks++;
        if (!ok || wq_data.size() < 4 || wq_data[2] !== 'h7FFD ||
            wq_data[3] !== 'h7FF9)
            $display("FAIL max_t23 got ok=%0d n=%0d want 7FFD/7FF9", ok,
                     wq_data.size());
        else n_pass++;
        for (int i = 0; i < N && i < wq_addr.size(); i++) begin
            n_checks++;
            if (wq_addr[i] !== i || wq_data[i] !== int'(exp_t[i]))
                $display("FAIL max_w%0d got a=%0d d=%h want a=%0d d=%h",
                         i, wq_addr[i], wq_data[i], i, exp_t[i]);
            else n_pass++;
        end
        n_checks++;
        if (sat !== exp_sat) $display("FAIL max_sat got %b want %b", sat, exp_sat);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        ready = 1'b1;
        kick(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (en !== 1'b1 || addr !== 3'd2 || data !== 16'h8001)
                $display("FAIL stall_hold%0d got en=%b a=%0d d=%h want 1/2/8001",
                         i, en, addr, data);
            else n_pass++;
            @(posedge clk);
        end
        #1;
        ready = 1'b1;
        wait_done(60, ok);
        n_checks++;
        if (!ok || dq[0] !== 18)
            $display("FAIL stall_done got ok=%0d cyc=%0d want 1/18", ok,
                     ok ? dq[0] : -1);
        else n_pass++;
        n_checks++;
        if (wq_addr.size() !== N || wq_addr[2] !== 2 || wq_cyc[2] !== 7 ||
            wq_cyc[N-1] !== wcyc(N - 1, 3))
            $display("FAIL stall_writes got n=%0d want %0d (addr2 at 7)",
                     wq_addr.size(), N);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok;
        ready = 1'b1;
        kick(16'h1234);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, ok);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || wq_addr.size() !== N || dq.size() !== 1 || dq[0] !== 15 ||
            busy !== 1'b0)
            $display("FAIL ign_start got writes=%0d dones=%0d busy=%b want %0d/1/0",
                     wq_addr.size(), dq.size(), busy, N);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        logic [15:0] xv;
        ready = 1'b1;
        kick(16'h0000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr !== 3'd0 ||
            data !== 16'h0)
            $display("FAIL rst_async got en=%b busy=%b a=%0d d=%h want 0/0/0/0",
                     en, busy, addr, data);
        else n_pass++;
        n_checks++;
        if (wq_addr.size() !== 3)
            $display("FAIL rst_abort got %0d writes want 3", wq_addr.size());
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (en !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_hold got en=%b busy=%b want 0/0", en, busy);
        else n_pass++;
        rst_n = 1'b1;
        xv = 16'($urandom);
        model(xv);
        kick(xv);
        wait_done(60, ok);
        n_checks++;
        if (!ok || wq_addr.size() !== N || wq_addr[0] !== 0 ||
            wq_data[N-1] !== int'(exp_t[N-1]))
            $display("FAIL rst_rerun got ok=%0d n=%0d want 1/%0d", ok,
                     wq_addr.size(), N);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] xv;
        int n;
        bit good;
        for (int r = 0; r < 8; r++) begin
            xv = 16'($urandom);
            if (r == 0) xv = 16'hC000;
            model(xv);
            kick(xv);
            n = 0;
            while (dq.size() == 0 && n < 400) begin
                @(posedge clk);
                #1;
                ready = ($urandom_range(0, 3) != 0);
                n++;
            end
            ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            good = (dq.size() == 1) && (wq_addr.size() == N);
            for (int i = 0; good && i < N; i++) begin
                if (wq_addr[i] !== i || wq_data[i] !== int'(exp_t[i]))
                    good = 1'b0;
            end
            n_checks++;
            if (!good)
                $display("FAIL rand%0d x=%h got n=%0d d_last=%h want n=%0d d_last=%h",
                         r, xv, wq_addr.size(),
                         wq_data.size() > 0 ? wq_data[wq_data.size()-1] : -1,
                         N, exp_t[N-1]);
            else n_pass++;
            n_checks++;
            if (sat !== exp_sat)
                $display("FAIL rand%0d_sat x=%h got %b want %b", r, xv, sat, exp_sat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_min();
        test_max();
        test_stall();
        test_start_ignored();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cheby_t_table_writer.md
CHEBY_T_TABLE_WRITER -- requirements
Module: cheby_t_table_writer

Interface
REQ-001 SHALL have parameter N_TERMS, default 8, number of table entries written, T(0) to T(N_TERMS-1), legal range 2 to 2^ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 3, table address width.
REQ-003 SHALL have port c_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port c_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port c_start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port i_x  input  16  evaluation point x, signed Q1.15.
REQ-007 SHALL have port c_wr_ready  input  1  table accepts write this cycle.
REQ-008 SHALL have port o_wr_en  output  1  write request.
REQ-009 SHALL have port o_wr_addr  output  ADDR_W  table address k.
REQ-010 SHALL have port o_wr_data  output  16  T(k)(x), signed Q1.15.
REQ-011 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port o_sat  output  1  sticky: a saturation occurred in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, W0, W1, CALC, WR, DONE.
REQ-015 IDLE with c_start=1 at an edge: latch i_x into x_reg, clear o_sat, go to W0; i_x is ignored at all other times.
REQ-016 W0: o_wr_en=1, o_wr_addr=0, o_wr_data=16'h7FFF (T0=1 saturated).
REQ-017 W1: o_wr_en=1, o_wr_addr=1, o_wr_data=x_reg.
REQ-018 CALC: one cycle, o_wr_en=0; computes T(k) for the next k and registers it; k increments.
REQ-019 WR: o_wr_en=1, o_wr_addr=k, o_wr_data=registered T(k).
REQ-020 Handshake: a write completes at an edge where o_wr_en=1 and c_wr_ready=1; until then addr, data and state hold stable.
REQ-021 After a completed write: W0 goes to W1. W1 or WR goes to DONE if k=N_TERMS-1, otherwise to CALC.
REQ-022 DONE: o_done=1 for exactly one cycle, then IDLE; table results are held nowhere else.
REQ-023 Recurrence: T(k)=2*x*T(k-1)-T(k-2), using the values previously written for k-1 and k-2.
REQ-024 Arithmetic: p = x_reg*T(k-1), a 32-bit signed product.
REQ-025 Arithmetic: q = p>>>14, arithmetic shift, truncating toward minus infinity, kept at 18 bits signed.
REQ-026 Arithmetic: s = q - sign-extended T(k-2).
REQ-027 Arithmetic: s is saturated to [-32768, 32767]; if clipping occurs, o_sat is set.
REQ-028 c_start SHALL be ignored while o_busy=1, including in DONE.
REQ-029 With c_wr_ready held high, timing is: start edge E0, addr0 in cycle 1, addr1 in cycle 2, addr k in cycle 2k for k>=2, o_done in cycle 2(N_TERMS-1)+1.

Reset
REQ-030 c_rst_n low SHALL immediately force, without waiting for a clock: state=IDLE, o_wr_en=0, o_busy=0, o_done=0, o_sat=0, o_wr_addr=0, o_wr_data=0, k=0, x_reg=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no further writes; deassertion SHALL be treated as synchronous to c_clk.

Verification
REQ-032 i_x=16'h0000, c_wr_ready=1 -> writes at addr 0..7: 7FFF, 0000, 8001, 0000, 7FFF, 0000, 8001, 0000; o_done in cycle 15; o_sat=0.
REQ-033 i_x=16'h7FFF -> addr 0..3 data 7FFF, 7FFF, 7FFD, 7FF9; o_sat=0 after T3.
REQ-034 i_x=16'h8000 -> addr1=8000, addr2=7FFF (clipped from 32769); o_sat=1 and stays 1 until the next start.
REQ-035 c_wr_ready low for 3 cycles while addr2 is presented -> addr/data stable at 2/8001 (x=0); no advance; run completes 3 cycles late.
REQ-036 c_start pulsed in cycles 5 and 15 of a run -> ignored; exactly 8 writes; one o_done.
REQ-037 c_rst_n low in cycle 6 -> o_wr_en=0 and o_busy=0 before the next edge; a new start after release writes from addr 0.
